// File: rtl/sand_pkg.sv
// sand_pkg: register map and brush command layout shared by the falling-sand command path.
package sand_pkg;
  localparam int COORD_W = 8;
  localparam int RADIUS_W = 8;
  localparam int TYPE_W = 2;
  localparam logic [2:0] REG_X = 3'd0;
  localparam logic [2:0] REG_Y = 3'd1;
  localparam logic [2:0] REG_RAD = 3'd2;
  localparam logic [2:0] REG_TYP = 3'd3;
  localparam logic [2:0] REG_CMT = 3'd4;
  localparam logic [2:0] REG_STS = 3'd5;
  localparam logic [2:0] REG_DRP = 3'd6;
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [RADIUS_W-1:0] radius;
    logic [TYPE_W-1:0] ptype;
  } brush_cmd_t;
endpackage

// File: rtl/sand_cmd_fifo.sv
// sand_cmd_fifo: show-ahead sync FIFO; a push into a full FIFO is taken only alongside a pop.
module sand_cmd_fifo #(
  parameter int W = 26,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // head is masked while empty so stale or uninitialised entries never appear on the stream
  assign dout = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/sand_cmd_regs.sv
// sand_cmd_regs: Avalon-MM brush register file feeding a queued valid/ready brush command stream.
module sand_cmd_regs
  import sand_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COORD_W = sand_pkg::COORD_W,
  parameter int RADIUS_W = sand_pkg::RADIUS_W,
  parameter int TYPE_W = sand_pkg::TYPE_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                chipselect,
  input  logic                write,
  input  logic                read,
  input  logic [2:0]          address,
  input  logic [DATA_W-1:0]   writedata,
  output logic [DATA_W-1:0]   readdata,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic [COORD_W-1:0]  cmd_x,
  output logic [COORD_W-1:0]  cmd_y,
  output logic [RADIUS_W-1:0] cmd_radius,
  output logic [TYPE_W-1:0]   cmd_type
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int CMD_W = 2 * COORD_W + RADIUS_W + TYPE_W;
  logic [COORD_W-1:0] x, y;
  logic [RADIUS_W-1:0] radius;
  logic [TYPE_W-1:0] ptype;
  logic overflow;
  logic [DATA_W-1:0] drop_cnt, rd_val;
  logic [CW-1:0] count;
  logic full, empty, wr, push, pop, clr, rejected;
  logic unused_wd;
  assign unused_wd = &{1'b0, writedata};
  assign wr = chipselect && write;
  assign push = wr && address == REG_CMT;
  assign clr = wr && address == REG_STS && writedata[0];
  assign pop = cmd_valid && cmd_ready;
  assign rejected = push && full && !pop;
  assign cmd_valid = !empty;
  sand_cmd_fifo #(.W(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .din({x, y, radius, ptype}),
    .dout({cmd_x, cmd_y, cmd_radius, cmd_type}),
    .count(count),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    rd_val = '0;
    case (address)
      REG_X: rd_val = DATA_W'(x);
      REG_Y: rd_val = DATA_W'(y);
      REG_RAD: rd_val = DATA_W'(radius);
      REG_TYP: rd_val = DATA_W'(ptype);
      REG_STS: rd_val = DATA_W'({overflow, full, empty, count});
      REG_DRP: rd_val = drop_cnt;
      default: rd_val = '0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
      radius <= '0;
      ptype <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      readdata <= '0;
    end else begin
      x <= wr && address == REG_X ? writedata[COORD_W-1:0] : x;
      y <= wr && address == REG_Y ? writedata[COORD_W-1:0] : y;
      radius <= wr && address == REG_RAD ? writedata[RADIUS_W-1:0] : radius;
      ptype <= wr && address == REG_TYP ? writedata[TYPE_W-1:0] : ptype;
      overflow <= clr ? 1'b0 : rejected ? 1'b1 : overflow;
      drop_cnt <= clr ? '0 : rejected && drop_cnt != '1 ? drop_cnt + DATA_W'(1) : drop_cnt;
      readdata <= chipselect && read ? rd_val : readdata;
    end
  end
endmodule

// File: tb/tb_sand_cmd_regs.sv
// tb_sand_cmd_regs: directed and random traffic against a queue-based model of the brush register file.
module tb_sand_cmd_regs;
  import sand_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic chipselect = 1'b0, write = 1'b0, read = 1'b0, cmd_ready = 1'b0;
  logic [2:0] address = '0;
  logic [15:0] writedata = '0, readdata;
  logic cmd_valid;
  logic [7:0] cmd_x, cmd_y, cmd_radius;
  logic [1:0] cmd_type;
  int n_chk = 0, n_pass = 0;
  logic [7:0] m_x, m_y, m_r;
  logic [1:0] m_t;
  bit m_ovf;
  int m_drop;
  logic [15:0] m_rd;
  brush_cmd_t m_q[$];

  sand_cmd_regs dut (
    .clk(clk), .rst_n(rst_n), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .cmd_radius(cmd_radius), .cmd_type(cmd_type)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] rd_model(input logic [2:0] a);
    case (a)
      3'd0: return {8'h0, m_x};
      3'd1: return {8'h0, m_y};
      3'd2: return {8'h0, m_r};
      3'd3: return {14'h0, m_t};
      3'd5: return 16'({m_ovf, m_q.size() == 8, m_q.size() == 0, 4'(m_q.size())});
      3'd6: return 16'(m_drop);
      default: return 16'h0;
    endcase
  endfunction

  task automatic model_clear();
    m_x = 0; m_y = 0; m_r = 0; m_t = 0; m_ovf = 0; m_drop = 0; m_rd = 0;
    m_q.delete();
  endtask

  task automatic cyc(input bit c, input bit w, input bit r, input logic [2:0] a,
                     input logic [15:0] d, input bit rdy);
    bit popped;
    chipselect = c; write = w; read = r; address = a; writedata = d; cmd_ready = rdy;
    popped = m_q.size() > 0 && rdy;
    if (c && r) m_rd = rd_model(a);
    if (popped) void'(m_q.pop_front());
    if (c && w) begin
      if (a == 3'd0) m_x = d[7:0];
      if (a == 3'd1) m_y = d[7:0];
      if (a == 3'd2) m_r = d[7:0];
      if (a == 3'd3) m_t = d[1:0];
      if (a == 3'd4) begin
        if (m_q.size() < 8) m_q.push_back('{m_x, m_y, m_r, m_t});
        else begin
          m_ovf = 1;
          if (m_drop < 65535) m_drop++;
        end
      end
      if (a == 3'd5 && d[0]) begin
        m_ovf = 0;
        m_drop = 0;
      end
    end
    @(posedge clk);
    #1;
    check("valid", cmd_valid, m_q.size() > 0);
    if (m_q.size() > 0) check("head", {cmd_x, cmd_y, cmd_radius, cmd_type}, m_q[0]);
    check("rdata", readdata, m_rd);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [15:0] d, input bit rdy);
    cyc(1, 1, 0, a, d, rdy);
  endtask

  task automatic rd_reg(input logic [2:0] a, input bit rdy);
    cyc(1, 0, 1, a, 16'h0, rdy);
  endtask

  task automatic do_reset();
    chipselect = 0; write = 0; read = 0; cmd_ready = 0;
    rst_n = 0;
    #1;
    check("rst_valid", cmd_valid, 1'b0);
    check("rst_fields", {cmd_x, cmd_y, cmd_radius, cmd_type}, 26'h0);
    check("rst_rdata", readdata, 16'h0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    model_clear();
    do_reset();
    rd_reg(REG_STS, 0);
    check("t1_sts", readdata, 16'h0010);
    wr_reg(REG_X, 16'd10, 0);
    wr_reg(REG_Y, 16'd20, 0);
    wr_reg(REG_RAD, 16'd3, 0);
    wr_reg(REG_TYP, 16'd2, 0);
    wr_reg(REG_CMT, 16'h0, 0);
    check("t2_valid", cmd_valid, 1'b1);
    check("t2_cmd", {cmd_x, cmd_y, cmd_radius, cmd_type}, {8'd10, 8'd20, 8'd3, 2'd2});
    cyc(0, 0, 0, 0, 0, 1);
    check("t2_drained", cmd_valid, 1'b0);
    for (int i = 0; i < 9; i++) begin
      wr_reg(REG_X, 16'(i + 40), 0);
      wr_reg(REG_CMT, 16'h0, 0);
    end
    rd_reg(REG_STS, 0);
    check("t3_sts", readdata, 16'h0068);
    rd_reg(REG_DRP, 0);
    check("t3_drp", readdata, 16'h0001);
    wr_reg(REG_STS, 16'h0001, 0);
    rd_reg(REG_STS, 0);
    check("t6_sts_clr", readdata, 16'h0028);
    rd_reg(REG_DRP, 0);
    check("t6_drp_clr", readdata, 16'h0000);
    wr_reg(REG_CMT, 16'h0, 1);
    rd_reg(REG_STS, 0);
    check("t4_sts", readdata, 16'h0028);
    for (int i = 0; i < 8; i++) begin
      check("t3_order", cmd_x, 8'(i + 41));
      cyc(0, 0, 0, 0, 0, 1);
    end
    rd_reg(REG_STS, 0);
    check("t3_empty", readdata, 16'h0010);
    wr_reg(REG_X, 16'hABCD, 0);
    rd_reg(REG_X, 0);
    check("t5_x", readdata, 16'h00CD);
    cyc(0, 0, 0, 0, 0, 0);
    check("t5_hold", readdata, 16'h00CD);
    for (int i = 0; i < 3; i++) wr_reg(REG_CMT, 16'h0, 0);
    do_reset();
    rd_reg(REG_STS, 0);
    check("t6_rst_sts", readdata, 16'h0010);
    for (int i = 0; i < 3000; i++)
      cyc(($urandom % 8) != 0, $urandom % 2, $urandom % 2, 3'($urandom % 8), 16'($urandom),
          i < 1500 ? ($urandom % 4) == 0 : ($urandom % 4) != 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
